// File: rtl/pcie_pkg.sv
// Shared definitions for the PCIe receive path: word width, VC-select bit,
// default FIFO depths and the control FSM encoding.
package pcie_pkg;

  localparam int PCIE_DW        = 6;
  localparam int PCIE_VC_BIT    = PCIE_DW - 1;
  localparam int PCIE_VC_DEPTH  = 16;
  localparam int PCIE_OUT_DEPTH = 4;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } pcie_state_t;

endpackage

// File: rtl/pcie_rx_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count, used for
// both the per-VC buffers and the output buffer.
module pcie_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr,
  input  logic [W-1:0]           wdata,
  input  logic                   rd,
  output logic [W-1:0]           rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          do_wr, do_rd;

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign do_wr = wr && !full;
  assign do_rd = rd && !empty;
  assign rdata = mem[rptr];

  // NOTE: the storage array has no reset; only pointers and count define
  // validity, so clearing the RAM would cost flops and buy nothing.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_wr) wptr <= bump(wptr);
      if (do_rd) rptr <= bump(rptr);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/pcie_recv.sv
// Two-lane receiver: lane hold registers, per-VC FIFOs, VC0-priority output
// arbiter and status FSM. Define PCIE_RECV_CNT_EN for per-VC pop counters.
module pcie_recv
  import pcie_pkg::*;
#(
  parameter int DW        = PCIE_DW,
  parameter int VC_DEPTH  = PCIE_VC_DEPTH,
  parameter int OUT_DEPTH = PCIE_OUT_DEPTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          init,
  input  logic [3:0]    umbral_VC0,
  input  logic [3:0]    umbral_VC1,
  input  logic [1:0]    umbral_out,
  input  logic [DW-1:0] data_in0,
  input  logic [DW-1:0] data_in1,
  input  logic          valid_in0,
  input  logic          valid_in1,
  output logic          pause_in0,
  output logic          pause_in1,
  input  logic          pop_out,
  output logic [DW-1:0] data_out,
  output logic          out_empty,
  output logic          active_out,
  output logic          idle_out,
  output logic          error_out
`ifdef PCIE_RECV_CNT_EN
  ,
  output logic [7:0]    cnt_vc0,
  output logic [7:0]    cnt_vc1
`endif
);
  localparam int VB  = DW - 1;
  localparam int VCW = $clog2(VC_DEPTH) + 1;
  localparam int OCW = $clog2(OUT_DEPTH) + 1;

  pcie_state_t state, state_nx;

  logic [3:0]     thr_vc0, thr_vc1;
  logic [1:0]     thr_out;
  logic           hv0, hv1;
  logic [DW-1:0]  hd0, hd1;
  logic           rr;
  logic           af_vc0, af_vc1;

  logic [VCW-1:0] cnt0, cnt1, lim0, lim1;
  logic [OCW-1:0] ocnt, olim;
  logic           e0, e1, f0, f1, of;
  logic [DW-1:0]  q0, q1, oq;

  logic           halt, tgt0, tgt1, space0, space1;
  logic           want0, want1, contend, drain0, drain1;
  logic           acc0, acc1, wr0, wr1, mv0, mv1, owr, opop;
  logic [DW-1:0]  wd0, wd1, owd;
  logic           err_evt, busy;

  assign halt   = (state == ST_ERROR);
  assign lim0   = VCW'(VC_DEPTH) - VCW'(thr_vc0);
  assign lim1   = VCW'(VC_DEPTH) - VCW'(thr_vc1);
  assign olim   = OCW'(OUT_DEPTH) - OCW'(thr_out);
  assign space0 = (cnt0 < lim0);
  assign space1 = (cnt1 < lim1);

  // Hold drain and round-robin resolution between the two lanes.
  assign tgt0    = hd0[VB];
  assign tgt1    = hd1[VB];
  assign want0   = hv0 && !halt && (tgt0 ? space1 : space0);
  assign want1   = hv1 && !halt && (tgt1 ? space1 : space0);
  assign contend = want0 && want1 && (tgt0 == tgt1);
  assign drain0  = want0 && (!contend || !rr);
  assign drain1  = want1 && (!contend ||  rr);

  assign pause_in0 = halt || (state == ST_RESET) || (hv0 && !drain0) ||
                     (hv0 && (tgt0 ? af_vc1 : af_vc0));
  assign pause_in1 = halt || (state == ST_RESET) || (hv1 && !drain1) ||
                     (hv1 && (tgt1 ? af_vc1 : af_vc0));
  assign acc0 = valid_in0 && !pause_in0;
  assign acc1 = valid_in1 && !pause_in1;

  assign wr0 = (drain0 && !tgt0) || (drain1 && !tgt1);
  assign wr1 = (drain0 &&  tgt0) || (drain1 &&  tgt1);
  assign wd0 = (drain0 && !tgt0) ? hd0 : hd1;
  assign wd1 = (drain0 &&  tgt0) ? hd0 : hd1;

  // Output arbiter: VC0 strictly ahead of VC1.
  assign mv0  = !halt && (ocnt < olim) && !e0;
  assign mv1  = !halt && (ocnt < olim) && e0 && !e1;
  assign owr  = mv0 || mv1;
  assign owd  = mv0 ? q0 : q1;
  assign opop = pop_out && !out_empty && !halt;

  assign data_out = out_empty ? '0 : oq;
  assign err_evt  = (pop_out && out_empty) || (wr0 && f0) || (wr1 && f1) || (owr && of);
  assign busy     = hv0 || hv1 || !e0 || !e1 || !out_empty;

  pcie_rx_fifo #(.DEPTH(VC_DEPTH), .W(DW)) u_vc0 (
    .clk(clk), .reset(reset), .wr(wr0), .wdata(wd0), .rd(mv0),
    .rdata(q0), .count(cnt0), .full(f0), .empty(e0)
  );

  pcie_rx_fifo #(.DEPTH(VC_DEPTH), .W(DW)) u_vc1 (
    .clk(clk), .reset(reset), .wr(wr1), .wdata(wd1), .rd(mv1),
    .rdata(q1), .count(cnt1), .full(f1), .empty(e1)
  );

  pcie_rx_fifo #(.DEPTH(OUT_DEPTH), .W(DW)) u_out (
    .clk(clk), .reset(reset), .wr(owr), .wdata(owd), .rd(opop),
    .rdata(oq), .count(ocnt), .full(of), .empty(out_empty)
  );

  // NOTE: every signal assigned here gets a default first, so no path
  // through the block can leave it unassigned and infer a latch.
  always_comb begin
    state_nx = state;
    if (state != ST_ERROR) begin
      if (err_evt)                state_nx = ST_ERROR;
      else if (state == ST_RESET) state_nx = ST_INIT;
      else if (init)              state_nx = ST_INIT;
      else begin
        case (state)
          ST_INIT:   state_nx = ST_IDLE;
          ST_IDLE:   if (busy)  state_nx = ST_ACTIVE;
          ST_ACTIVE: if (!busy) state_nx = ST_IDLE;
          default:   ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_RESET;
      active_out <= 1'b0;
      idle_out   <= 1'b0;
      error_out  <= 1'b0;
      thr_vc0    <= '0;
      thr_vc1    <= '0;
      thr_out    <= '0;
      af_vc0     <= 1'b0;
      af_vc1     <= 1'b0;
      rr         <= 1'b0;
    end else begin
      state      <= state_nx;
      active_out <= (state_nx == ST_ACTIVE);
      idle_out   <= (state_nx == ST_IDLE);
      error_out  <= (state_nx == ST_ERROR);
      if (state == ST_INIT) begin
        thr_vc0 <= umbral_VC0;
        thr_vc1 <= umbral_VC1;
        thr_out <= umbral_out;
      end
      af_vc0 <= (cnt0 >= lim0);
      af_vc1 <= (cnt1 >= lim1);
      if (contend) rr <= ~rr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hv0 <= 1'b0;
      hv1 <= 1'b0;
      hd0 <= '0;
      hd1 <= '0;
    end else begin
      if (acc0) begin
        hv0 <= 1'b1;
        hd0 <= data_in0;
      end else if (drain0) begin
        hv0 <= 1'b0;
      end
      if (acc1) begin
        hv1 <= 1'b1;
        hd1 <= data_in1;
      end else if (drain1) begin
        hv1 <= 1'b0;
      end
    end
  end

`ifdef PCIE_RECV_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_vc0 <= '0;
      cnt_vc1 <= '0;
    end else if (state == ST_INIT) begin
      cnt_vc0 <= '0;
      cnt_vc1 <= '0;
    end else begin
      if (mv0 && cnt_vc0 != 8'hFF) cnt_vc0 <= cnt_vc0 + 8'd1;
      if (mv1 && cnt_vc1 != 8'hFF) cnt_vc1 <= cnt_vc1 + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pcie_recv.sv
// Directed bench for pcie_recv: reset, latency, round-robin, fill threshold,
// VC priority, error stickiness and (with PCIE_RECV_CNT_EN) pop counters.
module tb_pcie_recv;
  localparam int DW = 6;

  logic          clk = 1'b0;
  logic          reset, init, pop_out;
  logic [3:0]    umbral_VC0, umbral_VC1;
  logic [1:0]    umbral_out;
  logic [DW-1:0] data_in0, data_in1, data_out;
  logic          valid_in0, valid_in1, pause_in0, pause_in1;
  logic          out_empty, active_out, idle_out, error_out;
`ifdef PCIE_RECV_CNT_EN
  logic [7:0]    cnt_vc0, cnt_vc1;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pcie_recv dut (
    .clk(clk), .reset(reset), .init(init),
    .umbral_VC0(umbral_VC0), .umbral_VC1(umbral_VC1), .umbral_out(umbral_out),
    .data_in0(data_in0), .data_in1(data_in1),
    .valid_in0(valid_in0), .valid_in1(valid_in1),
    .pause_in0(pause_in0), .pause_in1(pause_in1),
    .pop_out(pop_out), .data_out(data_out), .out_empty(out_empty),
    .active_out(active_out), .idle_out(idle_out), .error_out(error_out)
`ifdef PCIE_RECV_CNT_EN
    , .cnt_vc0(cnt_vc0), .cnt_vc1(cnt_vc1)
`endif
  );

  task automatic drive_idle();
    init = 1'b0; pop_out = 1'b0;
    valid_in0 = 1'b0; valid_in1 = 1'b0;
    data_in0 = '0; data_in1 = '0;
  endtask

  // Reset, hold init for two INIT cycles, then settle in IDLE.
  task automatic do_reset_init(input logic [3:0] u0, input logic [3:0] u1, input logic [1:0] uo);
    drive_idle();
    umbral_VC0 = u0; umbral_VC1 = u1; umbral_out = uo;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    init  = 1'b1;
    repeat (3) @(negedge clk);
    init  = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    drive_idle();
    umbral_VC0 = 4'd2; umbral_VC1 = 4'd0; umbral_out = 2'd0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++; if (out_empty !== 1'b1) begin n_fail++; $display("FAIL reset_out_empty: got %b want 1", out_empty); end
    n_tests++; if (data_out !== 6'h00) begin n_fail++; $display("FAIL reset_data_out: got %h want 00", data_out); end
    n_tests++; if ({pause_in0, pause_in1} !== 2'b11) begin n_fail++; $display("FAIL reset_pause: got %b want 11", {pause_in0, pause_in1}); end
    n_tests++; if ({active_out, idle_out, error_out} !== 3'b000) begin n_fail++; $display("FAIL reset_status: got %b want 000", {active_out, idle_out, error_out}); end
    reset = 1'b0;
    #1;
    n_tests++; if ({pause_in0, pause_in1} !== 2'b11) begin n_fail++; $display("FAIL rst_state_pause: got %b want 11", {pause_in0, pause_in1}); end
    init = 1'b1;
    @(negedge clk);
    n_tests++; if ({active_out, idle_out, error_out} !== 3'b000) begin n_fail++; $display("FAIL init_status: got %b want 000", {active_out, idle_out, error_out}); end
    repeat (2) @(negedge clk);
    init = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++; if ({active_out, idle_out, error_out} !== 3'b010) begin n_fail++; $display("FAIL idle_status: got %b want 010", {active_out, idle_out, error_out}); end
    n_tests++; if ({pause_in0, pause_in1} !== 2'b00) begin n_fail++; $display("FAIL idle_pause: got %b want 00", {pause_in0, pause_in1}); end
  endtask

  // Single VC0 word 0x05 on lane 0: visible after edge k+2, idle->active->idle.
  task automatic test_single();
    data_in0 = 6'h05; valid_in0 = 1'b1;
    @(negedge clk);                       // edge k
    valid_in0 = 1'b0;
    n_tests++; if (out_empty !== 1'b1) begin n_fail++; $display("FAIL single_k_empty: got %b want 1", out_empty); end
    @(negedge clk);                       // edge k+1
    n_tests++; if (out_empty !== 1'b1) begin n_fail++; $display("FAIL single_k1_empty: got %b want 1", out_empty); end
    n_tests++; if (active_out !== 1'b1) begin n_fail++; $display("FAIL single_active: got %b want 1", active_out); end
    @(negedge clk);                       // edge k+2
    n_tests++; if (out_empty !== 1'b0) begin n_fail++; $display("FAIL single_k2_empty: got %b want 0", out_empty); end
    n_tests++; if (data_out !== 6'h05) begin n_fail++; $display("FAIL single_data: got %h want 05", data_out); end
    pop_out = 1'b1;
    @(negedge clk);
    pop_out = 1'b0;
    n_tests++; if (out_empty !== 1'b1) begin n_fail++; $display("FAIL single_popped: got %b want 1", out_empty); end
    @(negedge clk);
    n_tests++; if ({active_out, idle_out} !== 2'b01) begin n_fail++; $display("FAIL single_back_idle: got %b want 01", {active_out, idle_out}); end
  endtask

  // Both lanes stream VC1 words; expect L0w0,L1w0,L0w1,L1w1,... and opposite pauses.
  task automatic test_round_robin();
    int sent0, sent1, got;
    logic a0, a1;
    logic [DW-1:0] exp_w;
    do_reset_init(4'd0, 4'd0, 2'd0);
    sent0 = 0; sent1 = 0; got = 0;
    for (int cyc = 0; cyc < 120 && got < 16; cyc++) begin
      valid_in0 = (sent0 < 8); data_in0 = 6'(32 + sent0);
      valid_in1 = (sent1 < 8); data_in1 = 6'(48 + sent1);
      pop_out   = !out_empty;
      if (!out_empty) begin
        exp_w = (got % 2 == 0) ? 6'(32 + got / 2) : 6'(48 + got / 2);
        n_tests++; if (data_out !== exp_w) begin n_fail++; $display("FAIL rr_word%0d: got %h want %h", got, data_out, exp_w); end
        got++;
      end
      if (cyc >= 1 && cyc <= 12) begin
        n_tests++; if (pause_in0 !== ~pause_in1) begin n_fail++; $display("FAIL rr_pause_cyc%0d: got %b%b want opposite", cyc, pause_in0, pause_in1); end
      end
      a0 = valid_in0 && !pause_in0;
      a1 = valid_in1 && !pause_in1;
      @(negedge clk);
      if (a0) sent0++;
      if (a1) sent1++;
    end
    drive_idle();
    n_tests++; if (got !== 16) begin n_fail++; $display("FAIL rr_count: got %0d want 16", got); end
  endtask

  // Fill VC0 with no pops: 4 out + 14 VC0 + 1 hold accepted, then pause holds.
  task automatic test_fill_threshold();
    int acc;
    logic risen;
    do_reset_init(4'd2, 4'd0, 2'd0);
    umbral_VC0 = 4'd0;                    // not in INIT: must be ignored
    acc = 0; risen = 1'b0;
    for (int cyc = 0; cyc < 60 && !risen; cyc++) begin
      valid_in0 = 1'b1; data_in0 = 6'((acc + 1) % 32);
      if (pause_in0) risen = 1'b1;
      else begin
        @(negedge clk);
        acc++;
      end
    end
    n_tests++; if (risen !== 1'b1) begin n_fail++; $display("FAIL fill_timeout: pause_in0 never rose"); end
    n_tests++; if (acc !== 19) begin n_fail++; $display("FAIL fill_accepted: got %0d want 19", acc); end
    repeat (5) @(negedge clk);
    n_tests++; if (pause_in0 !== 1'b1) begin n_fail++; $display("FAIL fill_pause_hold: got %b want 1", pause_in0); end
    n_tests++; if (error_out !== 1'b0) begin n_fail++; $display("FAIL fill_no_error: got %b want 0", error_out); end
    n_tests++; if (data_out !== 6'h01) begin n_fail++; $display("FAIL fill_head: got %h want 01", data_out); end
    // Reset mid-transfer: everything stored is discarded.
    do_reset_init(4'd2, 4'd0, 2'd0);
    repeat (4) @(negedge clk);
    n_tests++; if (out_empty !== 1'b1) begin n_fail++; $display("FAIL flush_empty: got %b want 1", out_empty); end
    n_tests++; if (idle_out !== 1'b1) begin n_fail++; $display("FAIL flush_idle: got %b want 1", idle_out); end
  endtask

  // VC1 word 0x21 and VC0 word 0x01 arrive together: 0x01 leaves first.
  task automatic test_priority();
    do_reset_init(4'd0, 4'd0, 2'd0);
    data_in0 = 6'h21; valid_in0 = 1'b1;
    data_in1 = 6'h01; valid_in1 = 1'b1;
    @(negedge clk);                       // edge k
    valid_in0 = 1'b0; valid_in1 = 1'b0;
    @(negedge clk);                       // edge k+1: both holds drained
    n_tests++; if ({pause_in0, pause_in1} !== 2'b00) begin n_fail++; $display("FAIL prio_drained: got %b want 00", {pause_in0, pause_in1}); end
    @(negedge clk);                       // edge k+2
    n_tests++; if (data_out !== 6'h01) begin n_fail++; $display("FAIL prio_first: got %h want 01", data_out); end
    pop_out = 1'b1;
    @(negedge clk);
    n_tests++; if (data_out !== 6'h21) begin n_fail++; $display("FAIL prio_second: got %h want 21", data_out); end
    @(negedge clk);
    pop_out = 1'b0;
    n_tests++; if (out_empty !== 1'b1) begin n_fail++; $display("FAIL prio_drain: got %b want 1", out_empty); end
  endtask

  // Pop on an empty output FIFO: sticky ERROR, both lanes paused.
  task automatic test_error();
    do_reset_init(4'd0, 4'd0, 2'd0);
    pop_out = 1'b1;
    @(negedge clk);
    pop_out = 1'b0;
    n_tests++; if ({active_out, idle_out, error_out} !== 3'b001) begin n_fail++; $display("FAIL err_status: got %b want 001", {active_out, idle_out, error_out}); end
    n_tests++; if ({pause_in0, pause_in1} !== 2'b11) begin n_fail++; $display("FAIL err_pause: got %b want 11", {pause_in0, pause_in1}); end
    data_in0 = 6'h05; valid_in0 = 1'b1;
    data_in1 = 6'h25; valid_in1 = 1'b1;
    init = 1'b1;
    repeat (3) @(negedge clk);
    init = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++; if (error_out !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", error_out); end
    n_tests++; if (out_empty !== 1'b1) begin n_fail++; $display("FAIL err_no_move: got %b want 1", out_empty); end
    n_tests++; if ({pause_in0, pause_in1} !== 2'b11) begin n_fail++; $display("FAIL err_pause_hold: got %b want 11", {pause_in0, pause_in1}); end
    do_reset_init(4'd0, 4'd0, 2'd0);
    n_tests++; if ({error_out, idle_out} !== 2'b01) begin n_fail++; $display("FAIL err_cleared: got %b want 01", {error_out, idle_out}); end
  endtask

`ifdef PCIE_RECV_CNT_EN
  // 300 VC0 words through: VC0 counter saturates, VC1 counter stays zero.
  task automatic test_counters();
    int sent, got;
    logic a0;
    do_reset_init(4'd0, 4'd0, 2'd0);
    sent = 0; got = 0;
    for (int cyc = 0; cyc < 2000 && got < 300; cyc++) begin
      valid_in0 = (sent < 300); data_in0 = 6'(sent % 32);
      pop_out   = !out_empty;
      if (!out_empty) got++;
      a0 = valid_in0 && !pause_in0;
      @(negedge clk);
      if (a0) sent++;
    end
    drive_idle();
    n_tests++; if (got !== 300) begin n_fail++; $display("FAIL cnt_words: got %0d want 300", got); end
    n_tests++; if (cnt_vc0 !== 8'd255) begin n_fail++; $display("FAIL cnt_vc0: got %0d want 255", cnt_vc0); end
    n_tests++; if (cnt_vc1 !== 8'd0) begin n_fail++; $display("FAIL cnt_vc1: got %0d want 0", cnt_vc1); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_fill_threshold();
    test_priority();
    test_error();
`ifdef PCIE_RECV_CNT_EN
    test_counters();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
